// File: rtl/ncl_count_reader_if.sv
// Valid/ready port carrying each completed count word out of the reader.
interface ncl_count_reader_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] count;
  logic             count_valid;
  logic             count_ready;

  modport master (output count, output count_valid, input count_ready);
  modport slave  (input count, input count_valid, output count_ready);
endinterface

// File: rtl/ncl_count_reader.sv
// Clocked receiver for a dual-rail NCL counter sum word: synchronizes the rails,
// detects DATA/NULL completeness, drives the ring acknowledge and emits counts.
module ncl_count_reader #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   init,
  input  logic [2*WIDTH-1:0]     sum_dr,
  output logic                   sumcomp,
  ncl_count_reader_if.master     cnt,
  output logic                   rail_err,
  output logic                   seq_err,
  output logic [15:0]            words
);

  typedef enum logic {WAIT_DATA, WAIT_NULL} state_t;

  state_t state_reg, state_next;

  logic [2*WIDTH-1:0] sync_reg [SYNC_STAGES];
  logic [2*WIDTH-1:0] samp;
  logic [2*WIDTH-1:0] prev_reg;

  logic [WIDTH-1:0] bit_data;
  logic [WIDTH-1:0] bit_both;
  logic [WIDTH-1:0] decoded;
  logic [WIDTH-1:0] last_reg;
  logic [WIDTH-1:0] last_inc;
  logic [WIDTH-1:0] count_reg;
  logic             count_valid_reg;
  logic             first_done_reg;
  logic             rail_err_reg;
  logic             seq_err_reg;
  logic [15:0]      words_reg;

  logic stable;
  logic data_complete;
  logic null_complete;
  logic slot_free;
  logic capture;

  // First stage takes the raw asynchronous rails; later stages only settle metastability.
  always_ff @(posedge clk) begin
    if (init) sync_reg[0] <= '0;
    else      sync_reg[0] <= sum_dr;
  end

  for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
    always_ff @(posedge clk) begin
      if (init) sync_reg[gi] <= '0;
      else      sync_reg[gi] <= sync_reg[gi-1];
    end
  end

  assign samp = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (init) prev_reg <= '0;
    else      prev_reg <= samp;
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign bit_data[gi] = samp[2*gi] ^ samp[2*gi+1];
    assign bit_both[gi] = samp[2*gi] & samp[2*gi+1];
    assign decoded[gi]  = samp[2*gi+1];
  end

  assign stable        = (samp == prev_reg);
  assign data_complete = &bit_data;
  assign null_complete = ~|samp;
  assign slot_free     = ~count_valid_reg | cnt.count_ready;
  assign last_inc      = last_reg + WIDTH'(1);

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    case (state_reg)
      WAIT_DATA: begin
        // Holding off the capture keeps sumcomp low, which stalls the ring in DATA.
        if (stable && data_complete && slot_free) begin
          capture    = 1'b1;
          state_next = WAIT_NULL;
        end
      end
      WAIT_NULL: begin
        if (stable && null_complete) state_next = WAIT_DATA;
      end
      default: state_next = WAIT_DATA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (init) begin
      state_reg       <= WAIT_DATA;
      count_reg       <= '0;
      count_valid_reg <= 1'b0;
      first_done_reg  <= 1'b0;
      last_reg        <= '0;
      rail_err_reg    <= 1'b0;
      seq_err_reg     <= 1'b0;
      words_reg       <= '0;
    end else begin
      state_reg <= state_next;
      if (capture) begin
        count_reg       <= decoded;
        count_valid_reg <= 1'b1;
        words_reg       <= words_reg + 16'd1;
        if (first_done_reg && (decoded != last_inc)) seq_err_reg <= 1'b1;
        first_done_reg  <= 1'b1;
        last_reg        <= decoded;
      end else if (cnt.count_ready) begin
        count_valid_reg <= 1'b0;
      end
      if (|bit_both) rail_err_reg <= 1'b1;
    end
  end

  assign sumcomp         = (state_reg == WAIT_NULL);
  assign cnt.count       = count_reg;
  assign cnt.count_valid = count_valid_reg;
  assign rail_err        = rail_err_reg;
  assign seq_err         = seq_err_reg;
  assign words           = words_reg;

endmodule

// File: tb/tb_ncl_count_reader.sv
// Scoreboard bench for ncl_count_reader: a behavioural ring model issues dual-rail
// words, expected counts are queued, and a monitor checks every drained word.
module tb_ncl_count_reader;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           init = 1'b1;
  logic [2*W-1:0] sum_dr = '0;
  logic           sumcomp;
  logic           rail_err;
  logic           seq_err;
  logic [15:0]    words;

  ncl_count_reader_if #(.WIDTH(W)) cif();

  ncl_count_reader #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .init     (init),
    .sum_dr   (sum_dr),
    .sumcomp  (sumcomp),
    .cnt      (cif.master),
    .rail_err (rail_err),
    .seq_err  (seq_err),
    .words    (words)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int ready_mode = 1;       // 0 = hold low, 1 = hold high, 2 = random
  logic [W-1:0] exp_q[$];

  // reference model state
  logic [W-1:0] m_last;
  bit           m_first;
  bit           m_seq_err;
  int           m_words;

  function automatic logic [2*W-1:0] encode(input logic [W-1:0] w);
    logic [2*W-1:0] r;
    for (int i = 0; i < W; i++) r[2*i +: 2] = w[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_capture(input logic [W-1:0] w);
    logic [W-1:0] nxt;
    nxt = m_last + W'(1);
    exp_q.push_back(w);
    if (m_first && (w != nxt)) m_seq_err = 1'b1;
    m_first = 1'b1;
    m_last  = w;
    m_words++;
  endtask

  task automatic wait_sc(input logic val, input string name);
    for (int n = 0; n < 300 && sumcomp !== val; n++) @(negedge clk);
    chk(name, sumcomp, val);
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 300 && exp_q.size() != 0; n++) @(negedge clk);
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic deliver(input logic [W-1:0] w);
    @(posedge clk); #2;
    sum_dr = encode(w);
    model_capture(w);
    wait_sc(1'b1, "sumcomp_up");
    @(posedge clk); #2;
    sum_dr = '0;
    wait_sc(1'b0, "sumcomp_down");
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    init   = 1'b1;
    sum_dr = {$urandom, $urandom};
    repeat (3) @(posedge clk);
    #2;
    sum_dr = '0;
    init   = 1'b0;
    exp_q.delete();
    m_last = '0; m_first = 1'b0; m_seq_err = 1'b0; m_words = 0;
  endtask

  // count_ready driver
  initial begin
    cif.count_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       cif.count_ready = 1'b0;
        1:       cif.count_ready = 1'b1;
        default: cif.count_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // monitor: every accepted word is checked against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!init && cif.count_valid && cif.count_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_word: got %0h expected none", cif.count);
        end else begin
          $display("xfer count=%08h words=%0d", cif.count, words);
          chk("count", cif.count, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0]   a, b, v, w;
    logic [2*W-1:0] enc, cur;
    m_last = '0; m_first = 1'b0; m_seq_err = 1'b0; m_words = 0;

    // reset with arbitrary rails
    sum_dr = {$urandom, $urandom};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sumcomp", sumcomp, 0);
    chk("rst_count", cif.count, 0);
    chk("rst_valid", cif.count_valid, 0);
    chk("rst_rail_err", rail_err, 0);
    chk("rst_seq_err", seq_err, 0);
    chk("rst_words", words, 0);
    @(posedge clk); #2;
    sum_dr = '0;
    init   = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_valid", cif.count_valid, 0);
    chk("idle_words", words, 0);

    // single word: exact latency
    ready_mode = 1;
    @(posedge clk); #2;
    sum_dr = encode(32'h0000_0005);
    model_capture(32'h0000_0005);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sc_early", sumcomp, 0);
    @(posedge clk);
    @(negedge clk);
    chk("sc_capture", sumcomp, 1);
    chk("valid_capture", cif.count_valid, 1);
    @(negedge clk);
    chk("valid_pulse", cif.count_valid, 0);
    @(posedge clk); #2;
    sum_dr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sc_null_early", sumcomp, 1);
    @(posedge clk);
    @(negedge clk);
    chk("sc_null", sumcomp, 0);
    wait_drain();

    // sequence across the wrap point
    do_reset();
    ready_mode = 2;
    deliver(32'hFFFF_FFFE);
    deliver(32'hFFFF_FFFF);
    deliver(32'h0000_0000);
    deliver(32'h0000_0001);
    wait_drain();
    chk("wrap_seq_err", seq_err, 0);
    chk("wrap_words", words, 4);

    // skip detection and stickiness
    do_reset();
    ready_mode = 1;
    deliver(32'd7);
    chk("skip_before", seq_err, 0);
    deliver(32'd9);
    chk("skip_seq_err", seq_err, 1);
    deliver(32'd10);
    chk("skip_sticky", seq_err, 1);
    chk("skip_words", words, 3);
    wait_drain();

    // backpressure: B waits behind undrained A, then drain and capture coincide
    do_reset();
    ready_mode = 0;
    a = $urandom;
    b = a + W'(1);
    deliver(a);
    @(posedge clk); #2;
    sum_dr = encode(b);
    model_capture(b);
    repeat (12) @(negedge clk);
    chk("bp_sumcomp", sumcomp, 0);
    chk("bp_count_held", cif.count, {32'd0, a});
    chk("bp_valid", cif.count_valid, 1);
    chk("bp_words", words, 1);
    @(posedge clk);
    ready_mode = 1;
    @(posedge clk);
    ready_mode = 0;
    @(negedge clk);
    chk("bp_valid_kept", cif.count_valid, 1);
    chk("bp_count_b", cif.count, {32'd0, b});
    chk("bp_sumcomp_up", sumcomp, 1);
    chk("bp_words2", words, 2);
    @(posedge clk); #2;
    sum_dr = '0;
    ready_mode = 1;
    wait_sc(1'b0, "bp_null");
    wait_drain();
    chk("bp_seq_err", seq_err, 0);

    // skewed arrival: four bits per cycle over eight cycles
    do_reset();
    w   = $urandom;
    enc = encode(w);
    cur = '0;
    for (int step = 0; step < 8; step++) begin
      @(posedge clk); #2;
      cur[step*8 +: 8] = enc[step*8 +: 8];
      sum_dr = cur;
      if (step < 7) begin
        @(negedge clk);
        chk("skew_partial", {words, 15'd0, sumcomp}, 0);
      end
    end
    model_capture(w);
    wait_sc(1'b1, "skew_up");
    chk("skew_words", words, 1);
    @(posedge clk); #2;
    sum_dr = '0;
    wait_sc(1'b0, "skew_down");
    chk("skew_words_after", words, 1);
    wait_drain();

    // both-rails-high bit blocks capture and sets rail_err
    do_reset();
    w   = $urandom;
    enc = encode(w);
    enc[7:6] = 2'b11;
    @(posedge clk); #2;
    sum_dr = enc;
    repeat (10) @(negedge clk);
    chk("rail_err_set", rail_err, 1);
    chk("rail_no_capture", words, 0);
    chk("rail_sumcomp", sumcomp, 0);
    @(posedge clk); #2;
    enc[7:6] = w[3] ? 2'b10 : 2'b01;
    sum_dr = enc;
    model_capture(w);
    wait_sc(1'b1, "rail_resolved_up");
    chk("rail_err_sticky", rail_err, 1);
    @(posedge clk); #2;
    sum_dr = '0;
    wait_sc(1'b0, "rail_resolved_down");
    wait_drain();

    // randomized run with occasional skips
    do_reset();
    ready_mode = 2;
    v = $urandom;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 7) == 0) v = v + W'($urandom_range(2, 5));
      deliver(v);
      v = v + W'(1);
    end
    wait_drain();
    chk("rand_seq_err", seq_err, m_seq_err);
    chk("rand_words", words, m_words[15:0]);
    chk("rand_rail_err", rail_err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
